pcpu_imem_loader: RTL

Instruction-memory and boot controller sitting directly upstream of the pipelined CPU's IF stage. It owns a 256 x 16 instruction RAM, fills it from a 16-bit valid/ready load stream, holds the CPU in reset while loading, then releases it by driving `enable` high and pulsing `start`. During run it serves instruction fetches by returning RAM contents for the CPU's `i_addr`.

---
 rtl/pcpu_imem_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pcpu_imem_loader.sv
// pcpu_imem_loader: 256x16 instruction RAM plus boot controller that loads it from a stream and releases the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 16-bit wrap-around checksum word after the data.
module pcpu_imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_datain,
    output logic              cpu_reset,
    output logic              cpu_enable,
    output logic              cpu_start,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_START,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W:0]     n;
    logic                xfer, last, we, in_chk;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
    assign in_chk = state_q == S_CHK;
`else
    assign in_chk = 1'b0;
`endif

    assign n          = load_data[ADDR_W:0];
    assign load_ready = state_q == S_IDLE || state_q == S_DATA || in_chk;
    assign xfer       = load_valid & load_ready;
    assign last       = {1'b0, addr_q} == len_q - (ADDR_W+1)'(1);
    assign cpu_enable = state_q == S_START || state_q == S_RUN;
    assign cpu_reset  = ~cpu_enable;
    assign cpu_start  = state_q == S_START;
    assign busy       = state_q == S_DATA || in_chk;
    assign error      = state_q == S_ERR;
    assign words_loaded = cnt_q;
    assign i_datain   = mem[i_addr];

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        // An abort outranks any word offered on the same edge; in IDLE it is a no-op.
        if (load_req && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (xfer) begin
                    if (n == '0 || n > MAX_N) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                        len_d   = n;
                        addr_d  = '0;
                        cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d   = '0;
`endif
                    end
                end
                S_DATA: if (xfer) begin
                    we     = 1'b1;
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + load_data;
                    if (last) state_d = S_CHK;
`else
                    if (last) state_d = S_START;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: if (xfer) state_d = load_data == sum_q ? S_START : S_ERR;
`endif
                S_START: state_d = S_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // RAM contents survive reset on purpose.
    always_ff @(posedge clock) begin
        if (we) mem[addr_q] <= load_data;
    end
endmodule
